// File: rtl/mux_n_reg_arb.sv
// N-to-1 registered selector with valid/ready on every channel; direct-select or round-robin mode.
// Optional sticky out-of-range select flag enabled by defining MUXN_SEL_CHECK_EN.
module mux_n_reg_arb #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumInputs = 4,
  parameter int unsigned SelWidth  = 2
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           Mode,
  input  logic [SelWidth-1:0]            Sel,
  input  logic [NumInputs*DataWidth-1:0] InBus,
  input  logic [NumInputs-1:0]           InValid,
  output logic [NumInputs-1:0]           InReady,
  output logic [DataWidth-1:0]           Out,
  output logic                           OutValid,
  input  logic                           OutReady,
  output logic [SelWidth-1:0]            Grant,
  output logic                           SelErr
);

  logic [SelWidth-1:0]  last;
  logic [SelWidth-1:0]  chosen;
  logic                 have;
  logic                 can_accept;
  logic                 accept;
  logic                 sel_in_range;
  logic [DataWidth-1:0] chosen_data;
  int unsigned          idx;

  assign sel_in_range = (32'(Sel) < NumInputs);
  assign can_accept   = !OutValid || OutReady;
  assign accept       = !Rst && can_accept && have;

  // Round-robin scans last+1, last+2, ... with explicit wrap so non-power-of-2 channel counts work.
  always_comb begin
    chosen = '0;
    have   = 1'b0;
    idx    = 0;
    if (!Mode) begin
      if (sel_in_range) begin
        chosen = Sel;
        for (int unsigned k = 0; k < NumInputs; k++) begin
          if (Sel == SelWidth'(k)) have = InValid[k];
        end
      end
    end else begin
      for (int unsigned i = 1; i <= NumInputs; i++) begin
        idx = 32'(last) + i;
        if (idx >= NumInputs) idx = idx - NumInputs;
        for (int unsigned k = 0; k < NumInputs; k++) begin
          if (!have && idx == k && InValid[k]) begin
            have   = 1'b1;
            chosen = SelWidth'(k);
          end
        end
      end
    end
  end

  always_comb begin
    InReady     = '0;
    chosen_data = '0;
    for (int unsigned k = 0; k < NumInputs; k++) begin
      InReady[k] = accept && (chosen == SelWidth'(k));
      if (chosen == SelWidth'(k)) chosen_data = InBus[k*DataWidth +: DataWidth];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Out      <= '0;
      OutValid <= 1'b0;
      Grant    <= '0;
      last     <= SelWidth'(NumInputs - 1);
    end else if (accept) begin
      Out      <= chosen_data;
      Grant    <= chosen;
      OutValid <= 1'b1;
      if (Mode) last <= chosen;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

`ifdef MUXN_SEL_CHECK_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      SelErr <= 1'b0;
    end else if (!Mode && !sel_in_range && (|InValid)) begin
      SelErr <= 1'b1;
    end
  end
`else
  assign SelErr = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_reg_arb.sv
// Self-checking bench for mux_n_reg_arb: directed vector table, randomized run against a
// behavioural model, and a 3-channel instance for out-of-range select handling.
module tb_mux_n_reg_arb;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int SW = 2;
`ifdef MUXN_SEL_CHECK_EN
  localparam logic SE = 1'b1;
`else
  localparam logic SE = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Mode;
  logic [SW-1:0] Sel;
  logic [N*DW-1:0] InBus;
  logic [N-1:0]  InValid, InReady;
  logic [DW-1:0] Out;
  logic          OutValid, OutReady;
  logic [SW-1:0] Grant;
  logic          SelErr;

  logic          mode3;
  logic [1:0]    sel3;
  logic [3*DW-1:0] inbus3;
  logic [2:0]    invalid3, inready3;
  logic [DW-1:0] out3;
  logic          ovalid3, oready3;
  logic [1:0]    grant3;
  logic          selerr3;

  mux_n_reg_arb #(.DataWidth(DW), .NumInputs(N), .SelWidth(SW)) dut (
    .Clk(Clk), .Rst(Rst), .Mode(Mode), .Sel(Sel), .InBus(InBus), .InValid(InValid),
    .InReady(InReady), .Out(Out), .OutValid(OutValid), .OutReady(OutReady),
    .Grant(Grant), .SelErr(SelErr));

  mux_n_reg_arb #(.DataWidth(DW), .NumInputs(3), .SelWidth(2)) dut3 (
    .Clk(Clk), .Rst(Rst), .Mode(mode3), .Sel(sel3), .InBus(inbus3), .InValid(invalid3),
    .InReady(inready3), .Out(out3), .OutValid(ovalid3), .OutReady(oready3),
    .Grant(grant3), .SelErr(selerr3));

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] ir;
    logic [31:0] out;
    logic       ov;
    logic [1:0] gr;
  } vec_t;

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] iv,
                              input logic ordy, input logic [3:0] ir, input logic [31:0] o,
                              input logic ov, input logic [1:0] g);
    vec_t v;
    v.mode = m; v.sel = s; v.iv = iv; v.ordy = ordy;
    v.ir = ir; v.out = o; v.ov = ov; v.gr = g;
    return v;
  endfunction

  // Reference model state
  logic [DW-1:0] m_out;
  logic          m_valid;
  int            m_grant;
  int            m_last;

  function automatic int pick(input logic mode, input int sel, input logic [N-1:0] v, input int last);
    if (!mode) return (sel < N && v[sel]) ? sel : -1;
    for (int d = 1; d <= N; d++) begin
      int c;
      c = (last + d) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_cycle();
    int c;
    logic [N-1:0] er;
    logic [DW-1:0] word;
    logic rst_s, mode_s, ordy_s;
    #1;
    c = (!Rst && (!m_valid || OutReady)) ? pick(Mode, int'(Sel), InValid, m_last) : -1;
    er = '0;
    word = '0;
    if (c >= 0) begin
      er[c] = 1'b1;
      word = InBus[c*DW +: DW];
    end
    rst_s = Rst; mode_s = Mode; ordy_s = OutReady;
    chk("rand inready", 128'(InReady), 128'(er));
    @(posedge Clk); #1;
    if (rst_s) begin
      m_out = '0; m_valid = 1'b0; m_grant = 0; m_last = N - 1;
    end else if (c >= 0) begin
      m_out = word; m_grant = c; m_valid = 1'b1;
      if (mode_s) m_last = c;
    end else if (ordy_s) begin
      m_valid = 1'b0;
    end
    chk("rand out", 128'(Out), 128'(m_out));
    chk("rand outvalid", 128'(OutValid), 128'(m_valid));
    chk("rand grant", 128'(Grant), 128'(m_grant));
    chk("rand selerr", 128'(SelErr), 128'(1'b0));
  endtask

  logic [31:0] CH [4];
  vec_t tbl [20];

  initial begin
    CH[0] = 32'h1111_1111; CH[1] = 32'h2222_2222; CH[2] = 32'hDEAD_BEEF; CH[3] = 32'h4444_4444;

    for (int i = 0; i < 8; i++)
      tbl[i] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (i % 4)), CH[i % 4], 1'b1, 2'(i % 4));
    tbl[8]  = mk(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, CH[2], 1'b1, 2'd2);
    tbl[9]  = mk(1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, CH[2], 1'b1, 2'd2);
    tbl[10] = mk(1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, CH[2], 1'b1, 2'd2);
    tbl[11] = mk(1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, CH[2], 1'b1, 2'd2);
    tbl[12] = mk(1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, CH[1], 1'b1, 2'd1);
    tbl[13] = mk(1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, CH[1], 1'b0, 2'd1);
    tbl[14] = mk(1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, CH[2], 1'b1, 2'd2);
    tbl[15] = mk(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, CH[1], 1'b1, 2'd1);
    tbl[16] = mk(1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, CH[0], 1'b1, 2'd0);
    tbl[17] = mk(1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, CH[0], 1'b0, 2'd0);
    tbl[18] = mk(1'b1, 2'd0, 4'b1000, 1'b0, 4'b1000, CH[3], 1'b1, 2'd3);
    tbl[19] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, CH[3], 1'b1, 2'd3);

    mode3 = 1'b0; sel3 = '0; inbus3 = '0; invalid3 = '0; oready3 = 1'b1;

    // Reset held two cycles with all channels requesting
    Rst = 1'b1; Mode = 1'b1; Sel = '0; InValid = 4'b1111; OutReady = 1'b1;
    InBus = {CH[3], CH[2], CH[1], CH[0]};
    for (int r = 0; r < 2; r++) begin
      #1;
      chk("reset inready", 128'(InReady), 128'(4'b0000));
      @(posedge Clk); #1;
      chk("reset out", 128'(Out), 128'(32'h0));
      chk("reset outvalid", 128'(OutValid), 128'(1'b0));
      chk("reset grant", 128'(Grant), 128'(2'd0));
      chk("reset selerr", 128'(SelErr), 128'(1'b0));
    end
    Rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      Mode = tbl[i].mode; Sel = tbl[i].sel; InValid = tbl[i].iv; OutReady = tbl[i].ordy;
      #1;
      chk($sformatf("row%0d inready", i), 128'(InReady), 128'(tbl[i].ir));
      @(posedge Clk); #1;
      chk($sformatf("row%0d out", i), 128'(Out), 128'(tbl[i].out));
      chk($sformatf("row%0d outvalid", i), 128'(OutValid), 128'(tbl[i].ov));
      chk($sformatf("row%0d grant", i), 128'(Grant), 128'(tbl[i].gr));
    end

    // Randomized run; starts with a reset so the model is in sync
    Rst = 1'b1;
    model_cycle();
    for (int n = 0; n < 3000; n++) begin
      Rst      = ($urandom_range(0, 63) == 0);
      Mode     = 1'($urandom);
      Sel      = SW'($urandom);
      InValid  = N'($urandom);
      OutReady = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) InBus[k*DW +: DW] = $urandom;
      model_cycle();
    end

    // Three-channel instance: out-of-range select and sticky error flag
    InValid = '0;
    Rst = 1'b1; mode3 = 1'b0; sel3 = 2'd3; invalid3 = 3'b111; oready3 = 1'b1;
    inbus3 = {CH[2], CH[1], CH[0]};
    @(posedge Clk); #1;
    chk("n3 reset selerr", 128'(selerr3), 128'(1'b0));
    Rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      #1;
      chk("n3 oor inready", 128'(inready3), 128'(3'b000));
      @(posedge Clk); #1;
      chk("n3 oor outvalid", 128'(ovalid3), 128'(1'b0));
      chk("n3 oor selerr", 128'(selerr3), 128'(SE));
    end
    sel3 = 2'd0; invalid3 = 3'b001;
    #1;
    chk("n3 sel0 inready", 128'(inready3), 128'(3'b001));
    @(posedge Clk); #1;
    chk("n3 sel0 outvalid", 128'(ovalid3), 128'(1'b1));
    chk("n3 sel0 out", 128'(out3), 128'(CH[0]));
    chk("n3 sel0 grant", 128'(grant3), 128'(2'd0));
    chk("n3 selerr held", 128'(selerr3), 128'(SE));
    mode3 = 1'b1; invalid3 = 3'b111;
    #1;
    chk("n3 rr wrap inready", 128'(inready3), 128'(3'b001));
    @(posedge Clk); #1;
    chk("n3 rr wrap grant", 128'(grant3), 128'(2'd0));
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("n3 selerr cleared", 128'(selerr3), 128'(1'b0));
    Rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
